gmii_rx_framer: RTL and testbench

GMII_RX_FRAMER -- requirements
Module: gmii_rx_framer

---
 rtl/gmii_rx_framer_if.sv | 27 ++
 rtl/gmii_rx_framer.sv | 177 +++++++++++++++++
 tb/tb_gmii_rx_framer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gmii_rx_framer_if.sv
// GMII receive inputs and PHY receive-FIFO write port seen by the framer.
interface gmii_rx_framer_if;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [7:0]  gmii_rxd;
    logic [17:0] phy_din;
    logic        phy_wr_en;
    logic        phy_full;

    modport master (
        input  gmii_rx_dv,
        input  gmii_rx_er,
        input  gmii_rxd,
        input  phy_full,
        output phy_din,
        output phy_wr_en
    );

    modport slave (
        output gmii_rx_dv,
        output gmii_rx_er,
        output gmii_rxd,
        output phy_full,
        input  phy_din,
        input  phy_wr_en
    );
endinterface

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD and packs frame bytes into flagged
// 16-bit words (little-first) for the PHY receive FIFO.
module gmii_rx_framer #(
    parameter int MAX_BYTES = 2047
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    gmii_rx_framer_if.master  bus,
    output logic [7:0]        phy_rx_count,
    output logic [15:0]       drop_count,
    output logic [15:0]       err_count
);
    localparam logic [1:0]  FL_MORE  = 2'b11;
    localparam logic [1:0]  FL_LAST2 = 2'b01;
    localparam logic [1:0]  FL_LAST1 = 2'b10;
    localparam logic [15:0] MAX_CNT  = 16'(MAX_BYTES);

    typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, FLUSH, TERM, DROP} state_t;
    state_t state;

    logic [7:0]  lo_p0;
    logic        vld_p0;
    logic [15:0] held_p1;
    logic        vld_p1;
    logic [17:0] din_p2;
    logic        vld_p2;
    logic [15:0] byte_cnt;
    logic        err_f;
    logic        ovf_f;
    logic        trunc_f;
    logic        bad;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign bad           = err_f | ovf_f;
    assign bus.phy_din   = din_p2;
    assign bus.phy_wr_en = vld_p2;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            lo_p0        <= 8'h00;
            vld_p0       <= 1'b0;
            held_p1      <= 16'h0000;
            vld_p1       <= 1'b0;
            din_p2       <= 18'h0;
            vld_p2       <= 1'b0;
            byte_cnt     <= 16'h0000;
            err_f        <= 1'b0;
            ovf_f        <= 1'b0;
            trunc_f      <= 1'b0;
            phy_rx_count <= 8'h00;
            drop_count   <= 16'h0000;
            err_count    <= 16'h0000;
        end else begin
            vld_p2 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.gmii_rx_dv) begin
                        if (bus.gmii_rxd == 8'h55) begin
                            state <= PREAMBLE;
                        end else begin
                            state      <= DROP;
                            drop_count <= sat_inc(drop_count);
                        end
                    end
                end
                PREAMBLE: begin
                    if (!bus.gmii_rx_dv) begin
                        state <= IDLE;
                    end else if (bus.gmii_rxd == 8'h55) begin
                        state <= PREAMBLE;
                    end else if (bus.gmii_rxd == 8'hD5 && !bus.phy_full) begin
                        state    <= DATA;
                        vld_p0   <= 1'b0;
                        vld_p1   <= 1'b0;
                        byte_cnt <= 16'h0000;
                        err_f    <= 1'b0;
                        ovf_f    <= 1'b0;
                        trunc_f  <= 1'b0;
                    end else begin
                        state      <= DROP;
                        drop_count <= sat_inc(drop_count);
                    end
                end
                // p0 assembles the low byte, p1 holds a completed pair, p2 is the FIFO write
                DATA: begin
                    if (bus.gmii_rx_dv) begin
                        if (bus.gmii_rx_er) err_f <= 1'b1;
                        if (!trunc_f) begin
                            // Oversize means a byte arrived that could not be stored.
                            if (byte_cnt == MAX_CNT) begin
                                ovf_f <= 1'b1;
                            end else begin
                                byte_cnt <= byte_cnt + 16'd1;
                                if (!vld_p0) begin
                                    lo_p0  <= bus.gmii_rxd;
                                    vld_p0 <= 1'b1;
                                end else begin
                                    vld_p0 <= 1'b0;
                                    if (!vld_p1) begin
                                        held_p1 <= {bus.gmii_rxd, lo_p0};
                                        vld_p1  <= 1'b1;
                                    end else if (bus.phy_full) begin
                                        trunc_f <= 1'b1;
                                        vld_p1  <= 1'b0;
                                    end else begin
                                        din_p2  <= {FL_MORE, held_p1};
                                        vld_p2  <= 1'b1;
                                        held_p1 <= {bus.gmii_rxd, lo_p0};
                                    end
                                end
                            end
                        end
                    end else if (trunc_f) begin
                        state <= TERM;
                    end else if (vld_p1) begin
                        if (bus.phy_full) begin
                            trunc_f <= 1'b1;
                            state   <= TERM;
                        end else begin
                            vld_p1 <= 1'b0;
                            vld_p2 <= 1'b1;
                            if (!vld_p0 && !bad) begin
                                din_p2       <= {FL_LAST2, held_p1};
                                phy_rx_count <= phy_rx_count + 8'd1;
                                state        <= IDLE;
                            end else begin
                                din_p2 <= {FL_MORE, held_p1};
                                state  <= vld_p0 ? FLUSH : TERM;
                            end
                        end
                    end else begin
                        state <= vld_p0 ? FLUSH : TERM;
                    end
                end
                FLUSH: begin
                    if (bus.phy_full) begin
                        trunc_f <= 1'b1;
                        state   <= TERM;
                    end else begin
                        vld_p0 <= 1'b0;
                        vld_p2 <= 1'b1;
                        if (bad) begin
                            din_p2 <= {FL_MORE, 8'h00, lo_p0};
                            state  <= TERM;
                        end else begin
                            din_p2       <= {FL_LAST1, 8'h00, lo_p0};
                            phy_rx_count <= phy_rx_count + 8'd1;
                            state        <= IDLE;
                        end
                    end
                end
                TERM: begin
                    if (!bus.phy_full) begin
                        din_p2       <= 18'h0;
                        vld_p2       <= 1'b1;
                        phy_rx_count <= phy_rx_count + 8'd1;
                        if (bad || trunc_f) err_count <= sat_inc(err_count);
                        if (bus.gmii_rx_dv) begin
                            state      <= DROP;
                            drop_count <= sat_inc(drop_count);
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (!bus.gmii_rx_dv) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gmii_rx_framer.sv
// Randomized bench for gmii_rx_framer against a frame-level word model.
module tb_gmii_rx_framer;
    localparam int MAX_BYTES = 2047;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  phy_rx_count;
    logic [15:0] drop_count;
    logic [15:0] err_count;

    gmii_rx_framer_if bus ();

    gmii_rx_framer #(.MAX_BYTES(MAX_BYTES)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .bus          (bus),
        .phy_rx_count (phy_rx_count),
        .drop_count   (drop_count),
        .err_count    (err_count)
    );

    always #4 sys_clk = ~sys_clk;

    int          n_vec = 0;
    int          n_miss = 0;
    logic [17:0] got_q[$];
    logic [17:0] exp_q[$];
    logic [7:0]  frm[$];
    int          lost = 0;
    int          lost_base = 0;
    int          got_base = 0;
    int          exp_rx = 0;
    int          exp_drop = 0;
    int          exp_err = 0;
    int          fc = 0;
    int          full_from = -1;
    int          full_len = 0;

    // Words the FIFO accepts; writes landing while full are lost.
    always @(negedge sys_clk) begin
        if (bus.phy_wr_en === 1'b1) begin
            if (bus.phy_full) lost <= lost + 1;
            else got_q.push_back(bus.phy_din);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic dv, input logic er, input logic [7:0] d);
        bus.phy_full   = (fc >= full_from) && (fc < full_from + full_len);
        bus.gmii_rx_dv = dv;
        bus.gmii_rx_er = er;
        bus.gmii_rxd   = d;
        fc++;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_frame(input int pre, input int er_at, input int ipg);
        fc = 0;
        for (int i = 0; i < pre; i++) cyc(1'b1, 1'b0, 8'h55);
        cyc(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < frm.size(); i++) cyc(1'b1, i == er_at, frm[i]);
        for (int i = 0; i < ipg; i++) cyc(1'b0, 1'b0, 8'h00);
        full_from = -1;
        full_len  = 0;
        bus.phy_full = 1'b0;
    endtask

    task automatic model_frame(input bit er);
        int         n;
        bit         bad;
        logic [1:0] fl;
        n   = (frm.size() > MAX_BYTES) ? MAX_BYTES : frm.size();
        bad = er || (frm.size() > MAX_BYTES);
        for (int k = 0; k + 1 < n; k += 2) begin
            fl = (!bad && k + 2 == n) ? 2'b01 : 2'b11;
            exp_q.push_back({fl, frm[k+1], frm[k]});
        end
        if (n % 2 == 1) exp_q.push_back({bad ? 2'b11 : 2'b10, 8'h00, frm[n-1]});
        if (bad || n == 0) exp_q.push_back(18'h0);
        exp_rx++;
        if (bad) exp_err++;
    endtask

    task automatic chk_counters(input string tag, input int lost_allow);
        chk({tag, "_rx_count"}, 32'(phy_rx_count), 32'(exp_rx[7:0]));
        chk({tag, "_drop"}, 32'(drop_count), 32'(exp_drop[15:0]));
        chk({tag, "_err"}, 32'(err_count), 32'(exp_err[15:0]));
        chk({tag, "_lost"}, 32'((lost - lost_base) <= lost_allow), 32'd1);
        lost_base = lost;
        got_base  = got_q.size();
        exp_q.delete();
    endtask

    task automatic check_all(input string tag);
        int ng;
        @(posedge sys_clk);
        #1;
        ng = got_q.size() - got_base;
        chk({tag, "_nwords"}, 32'(ng), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < ng; k++)
            chk({tag, "_word"}, 32'(got_q[got_base+k]), 32'(exp_q[k]));
        chk_counters(tag, 0);
    endtask

    task automatic check_trunc(input string tag);
        int          ng;
        logic [17:0] last;
        @(posedge sys_clk);
        #1;
        ng   = got_q.size() - got_base;
        last = (ng >= 1) ? got_q[got_q.size()-1] : 18'h3FFFF;
        chk({tag, "_short"}, 32'(ng >= 1 && ng < exp_q.size()), 32'd1);
        for (int k = 0; k + 1 < ng && k < exp_q.size(); k++)
            chk({tag, "_prefix"}, 32'(got_q[got_base+k]), 32'(exp_q[k]));
        chk({tag, "_term"}, 32'(last), 32'h0);
        chk_counters(tag, 1);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        sys_rst_n = 1'b1;
        exp_rx   = 0;
        exp_drop = 0;
        exp_err  = 0;
    endtask

    task automatic fill_seq(input int len);
        frm.delete();
        for (int i = 1; i <= len; i++) frm.push_back(8'(i));
    endtask

    task automatic fill_rand(input int len);
        frm.delete();
        for (int i = 0; i < len; i++) frm.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        int          n01;
        int          len;
        int          er_at;
        int          kind;
        logic [7:0]  b;
        bus.gmii_rx_dv = 1'b0;
        bus.gmii_rx_er = 1'b0;
        bus.gmii_rxd   = 8'h00;
        bus.phy_full   = 1'b0;
        do_reset();
        chk("rst_wr_en", 32'(bus.phy_wr_en), 32'd0);
        chk("rst_din", 32'(bus.phy_din), 32'd0);
        chk("rst_rx_count", 32'(phy_rx_count), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);

        fill_seq(64);
        send_frame(7, -1, 12);
        chk("f64_first", 32'(got_q[got_base]), 32'({2'b11, 16'h0201}));
        chk("f64_last", 32'(got_q[got_q.size()-1]), 32'({2'b01, 16'h403F}));
        model_frame(1'b0);
        check_all("f64");

        fill_seq(65);
        send_frame(7, -1, 12);
        chk("f65_w32", 32'(got_q[got_base+31]), 32'({2'b11, 16'h403F}));
        chk("f65_w33", 32'(got_q[got_base+32]), 32'({2'b10, 16'h0041}));
        model_frame(1'b0);
        check_all("f65");

        fill_seq(64);
        send_frame(7, 9, 12);
        model_frame(1'b1);
        check_all("rx_er");

        fill_seq(20);
        full_from = 7;
        full_len  = 20;
        send_frame(7, -1, 8);
        exp_drop++;
        check_all("sfd_full");

        fill_seq(64);
        full_from = 28;
        full_len  = 20;
        send_frame(7, -1, 12);
        model_frame(1'b0);
        exp_err++;
        check_trunc("mid_full");

        fill_seq(40);
        full_from = 38;
        full_len  = 20;
        send_frame(7, -1, 16);
        model_frame(1'b0);
        exp_err++;
        check_trunc("term_stall");

        do_reset();
        fill_seq(60);
        send_frame(7, -1, 12);
        model_frame(1'b0);
        send_frame(7, -1, 12);
        model_frame(1'b0);
        n01 = 0;
        for (int k = got_base; k < got_q.size(); k++) if (got_q[k][17:16] == 2'b01) n01++;
        chk("b2b_n01", 32'(n01), 32'd2);
        check_all("b2b");

        fc = 0;
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'h55);
        cyc(1'b1, 1'b0, 8'hD5);
        cyc(1'b1, 1'b0, frm[0]);
        cyc(1'b1, 1'b0, frm[1]);
        sys_rst_n = 1'b0;
        cyc(1'b1, 1'b0, frm[2]);
        sys_rst_n = 1'b1;
        for (int i = 3; i < frm.size(); i++) cyc(1'b1, 1'b0, frm[i]);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 8'h00);
        exp_rx   = 0;
        exp_drop = 1;
        exp_err  = 0;
        check_all("rst_mid");

        fill_rand(MAX_BYTES);
        send_frame(7, -1, 6);
        model_frame(1'b0);
        check_all("max_len");

        fill_rand(MAX_BYTES + 2);
        send_frame(7, -1, 6);
        model_frame(1'b0);
        check_all("oversize");

        for (int it = 0; it < 150; it++) begin
            kind = $urandom_range(0, 9);
            if (kind < 7) begin
                len = $urandom_range(0, 80);
                fill_rand(len);
                er_at = (len > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
                send_frame($urandom_range(1, 7), er_at, $urandom_range(3, 8));
                model_frame(er_at >= 0);
                check_all("rnd_frame");
            end else if (kind == 7) begin
                fc = 0;
                do b = 8'($urandom_range(0, 255)); while (b == 8'h55);
                cyc(1'b1, 1'b0, b);
                for (int i = 0; i < $urandom_range(0, 9); i++) cyc(1'b1, 1'b0, 8'($urandom_range(0, 255)));
                for (int i = 0; i < $urandom_range(3, 8); i++) cyc(1'b0, 1'b0, 8'h00);
                exp_drop++;
                check_all("rnd_junk");
            end else if (kind == 8) begin
                fc = 0;
                for (int i = 0; i < $urandom_range(1, 5); i++) cyc(1'b1, 1'b0, 8'h55);
                do b = 8'($urandom_range(0, 255)); while (b == 8'h55 || b == 8'hD5);
                cyc(1'b1, 1'b0, b);
                for (int i = 0; i < $urandom_range(0, 8); i++) cyc(1'b1, 1'b0, 8'($urandom_range(0, 255)));
                for (int i = 0; i < $urandom_range(3, 8); i++) cyc(1'b0, 1'b0, 8'h00);
                exp_drop++;
                check_all("rnd_badpre");
            end else begin
                fc = 0;
                for (int i = 0; i < $urandom_range(1, 7); i++) cyc(1'b1, 1'b0, 8'h55);
                for (int i = 0; i < $urandom_range(3, 8); i++) cyc(1'b0, 1'b0, 8'h00);
                check_all("rnd_abort");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
